// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU instruction sequencer: IDLE -> FETCH -> DECODE -> EXECUTE -> WRITEBACK,
// with a bounded fetch wait that parks the core in HALT with a sticky fault flag.
module cpu_sequencer #(
  parameter int unsigned PC_W          = 8,
  parameter int unsigned FETCH_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_rdata,
  input  logic            pc_jump,
  output logic [2:0]      state,
  output logic [3:0]      opcode,
  output logic [15:0]     instr,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            fault,
  output logic [15:0]     retired
);

  localparam int unsigned CNT_W = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT + 1);
  localparam logic [3:0]  OP_HALT = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE      = 3'b000,
    S_FETCH     = 3'b001,
    S_DECODE    = 3'b010,
    S_EXECUTE   = 3'b011,
    S_WRITEBACK = 3'b100,
    S_HALT      = 3'b101
  } state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [15:0]       instr_q, instr_d;
  logic [15:0]       retired_q, retired_d;
  logic              fault_q, fault_d;
  logic              jump_q, jump_d;
  logic [CNT_W-1:0]  wait_q, wait_d;

  // Next-state and datapath updates; every register holds unless its state touches it.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    fault_d   = fault_q;
    jump_d    = jump_q;
    wait_d    = wait_q;
    unique case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
          wait_d  = '0;
        end
      end
      S_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_DECODE;
        end else if (wait_q == CNT_W'(FETCH_TIMEOUT - 1)) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      S_DECODE: begin
        state_d = (instr_q[15:12] == OP_HALT) ? S_HALT : S_EXECUTE;
      end
      S_EXECUTE: begin
        jump_d  = pc_jump;
        state_d = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        pc_d    = jump_q ? instr_q[PC_W-1:0] : pc_q + PC_W'(1);
        if (retired_q != 16'hFFFF) retired_d = retired_q + 16'd1;
        wait_d  = '0;
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      instr_q   <= '0;
      retired_q <= '0;
      fault_q   <= 1'b0;
      jump_q    <= 1'b0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
      fault_q   <= fault_d;
      jump_q    <= jump_d;
      wait_q    <= wait_d;
    end
  end

  // Outputs are direct views of registered state.
  assign state     = state_q;
  assign imem_req  = (state_q == S_FETCH);
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign opcode    = instr_q[15:12];
  assign halted    = (state_q == S_HALT);
  assign fault     = fault_q;
  assign retired   = retired_q;

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 8, program counter and instruction-memory address width.
REQ-002 SHALL have parameter FETCH_TIMEOUT, default 15, maximum wait cycles for imem_ack in FETCH.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port run, input, 1, start request, sampled in IDLE only.
REQ-006 SHALL have port imem_req, output, 1, instruction-fetch request.
REQ-007 SHALL have port imem_addr, output, PC_W, fetch address, equal to pc.
REQ-008 SHALL have port imem_ack, input, 1, fetch data valid this cycle.
REQ-009 SHALL have port imem_rdata, input, 16, instruction word; opcode is bits [15:12].
REQ-010 SHALL have port pc_jump, input, 1, jump decision from the control unit, valid in EXECUTE.
REQ-011 SHALL have port state, output, 3, current sequencer state, driving the control unit.
REQ-012 SHALL have port opcode, output, 4, instr[15:12].
REQ-013 SHALL have port instr, output, 16, instruction register.
REQ-014 SHALL have port pc, output, PC_W, program counter.
REQ-015 SHALL have port halted, output, 1, high in HALT.
REQ-016 SHALL have port fault, output, 1, sticky fetch-timeout flag.
REQ-017 SHALL have port retired, output, 16, count of instructions completing WRITEBACK.

Function
REQ-018 SHALL encode states as IDLE=000, FETCH=001, DECODE=010, EXECUTE=011, WRITEBACK=100, HALT=101.
REQ-019 SHALL go from IDLE to FETCH on the cycle after run=1; stay in IDLE otherwise.
REQ-020 SHALL drive imem_req=1 combinationally in FETCH only, with imem_addr=pc held stable.
REQ-021 SHALL, in FETCH with imem_ack=1, load instr from imem_rdata and go to DECODE.
REQ-022 SHALL count FETCH wait cycles; at FETCH_TIMEOUT consecutive cycles without ack, set fault=1 and go to HALT; counter clears on entering FETCH.
REQ-023 SHALL, in DECODE, go to HALT when opcode=1111, else go to EXECUTE.
REQ-024 SHALL spend exactly one cycle in EXECUTE, latching pc_jump into an internal jump flag, then go to WRITEBACK.
REQ-025 SHALL, in WRITEBACK, load pc from instr[PC_W-1:0] if the jump flag is set, else pc+1 modulo 2^PC_W (wraps max to 0), then go to FETCH.
REQ-026 SHALL increment retired in WRITEBACK, saturating at 16'hFFFF.
REQ-027 SHALL keep HALT until rst; run is ignored in HALT.
REQ-028 SHALL return any unused state encoding (110, 111) to IDLE on the next cycle.
REQ-029 SHALL give a one-ack instruction latency of 4 cycles, FETCH through WRITEBACK.
REQ-030 SHALL ignore imem_ack outside FETCH.

Reset
REQ-031 SHALL, with rst=1 at a clock edge, set state=IDLE, pc=0, instr=0, retired=0, fault=0, jump flag=0, wait counter=0, in any state including mid-fetch.
REQ-032 SHALL give outputs after reset: imem_req=0, halted=0, opcode=0; rst overrides run and imem_ack in the same cycle.

Verification
REQ-033 SHALL cover: reset, run=1, ack at once with 16'h3000 (ADD), pc_jump=0 -> states 001,010,011,100, pc 0->1, retired=1.
REQ-034 SHALL cover: instr 16'h8042, pc_jump=1 in EXECUTE -> pc=8'h42 after WRITEBACK.
REQ-035 SHALL cover: pc=8'hFF, non-jump instruction -> pc wraps to 8'h00.
REQ-036 SHALL cover: imem_ack held low for 15 FETCH cycles -> fault=1, halted=1, state=101; with an ack on cycle 14 instead -> no fault.
REQ-037 SHALL cover: instr 16'hF000 -> HALT after DECODE, pc unchanged, retired unchanged; rst then returns to IDLE with all outputs zero.
REQ-038 SHALL cover: rst asserted during FETCH with imem_ack=1 -> state=IDLE, instr=0 next cycle.
